// File: rtl/audio_frame_double_buffer_if.sv
// Bus bundle for the audio ping-pong frame buffer.
// The master drives the sample stream, read address and FFT busy. The slave is the buffer.
interface audio_frame_double_buffer_if #(
  parameter int FFT_POINTS     = 512,
  parameter int DATA_WIDTH     = 24,
  parameter int DROP_CNT_WIDTH = 16
);
  localparam int AW = $clog2(FFT_POINTS);

  logic                      i_sample_valid;
  logic [DATA_WIDTH-1:0]     i_sample;
  logic [AW-1:0]             i_read_addr;
  logic [DATA_WIDTH-1:0]     o_read_data;
  logic                      o_data_ready;
  logic                      i_fft_busy;
  logic                      o_write_bank;
  logic [AW:0]               o_fill_count;
  logic                      o_overrun;
  logic [DROP_CNT_WIDTH-1:0] o_drop_count;

  modport master (
    output i_sample_valid, i_sample, i_read_addr, i_fft_busy,
    input  o_read_data, o_data_ready, o_write_bank, o_fill_count, o_overrun, o_drop_count
  );

  modport slave (
    input  i_sample_valid, i_sample, i_read_addr, i_fft_busy,
    output o_read_data, o_data_ready, o_write_bank, o_fill_count, o_overrun, o_drop_count
  );
endinterface

// File: rtl/audio_frame_double_buffer.sv
// Ping-pong frame buffer: one bank fills from the audio stream while the other is read by the FFT.
// A full bank with no free read slot stalls the writer, and samples are dropped until the FFT releases.
module audio_frame_double_buffer #(
  parameter int FFT_POINTS     = 512,
  parameter int DATA_WIDTH     = 24,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  audio_frame_double_buffer_if.slave bus
);
  localparam int AW = $clog2(FFT_POINTS);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL = FW'(FFT_POINTS);

  localparam logic [1:0] R_EMPTY   = 2'd0;
  localparam logic [1:0] R_PENDING = 2'd1;
  localparam logic [1:0] R_CLAIMED = 2'd2;

  logic [DATA_WIDTH-1:0]     mem [0:2*FFT_POINTS-1];

  logic [1:0]                state_reg, state_base, state_next;
  logic                      write_bank_reg, write_bank_next;
  logic                      read_bank_reg, read_bank_next;
  logic [FW-1:0]             fill_reg, fill_next;
  logic                      stall_reg, stall_next;
  logic                      ready_reg;
  logic                      overrun_reg;
  logic [DROP_CNT_WIDTH-1:0] drop_reg;
  logic [DATA_WIDTH-1:0]     rdata_reg;

  logic                      accept;
  logic                      frame_done;
  logic                      swap;

  assign accept     = bus.i_sample_valid && !stall_reg;
  assign frame_done = accept && (fill_reg == FULL - FW'(1));

  always_comb begin
    state_base = R_EMPTY;
    case (state_reg)
      R_PENDING: state_base = bus.i_fft_busy ? R_CLAIMED : R_PENDING;
      R_CLAIMED: state_base = bus.i_fft_busy ? R_CLAIMED : R_EMPTY;
      default:   state_base = R_EMPTY;
    endcase
  end

  // A completed bank can only be offered once the read side is empty after this cycle's transition.
  assign swap = (frame_done || stall_reg) && (state_base == R_EMPTY);

  always_comb begin
    state_next      = state_base;
    write_bank_next = write_bank_reg;
    read_bank_next  = read_bank_reg;
    fill_next       = fill_reg;
    stall_next      = stall_reg;
    if (swap) begin
      state_next      = R_PENDING;
      read_bank_next  = write_bank_reg;
      write_bank_next = ~write_bank_reg;
      fill_next       = '0;
      stall_next      = 1'b0;
    end else if (frame_done) begin
      fill_next  = FULL;
      stall_next = 1'b1;
    end else if (accept) begin
      fill_next = fill_reg + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= R_EMPTY;
      write_bank_reg <= 1'b0;
      read_bank_reg  <= 1'b1;
      fill_reg       <= '0;
      stall_reg      <= 1'b0;
      ready_reg      <= 1'b0;
      overrun_reg    <= 1'b0;
      drop_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      write_bank_reg <= write_bank_next;
      read_bank_reg  <= read_bank_next;
      fill_reg       <= fill_next;
      stall_reg      <= stall_next;
      ready_reg      <= (state_next == R_PENDING);
      overrun_reg    <= bus.i_sample_valid && stall_reg;
      if (bus.i_sample_valid && stall_reg && (drop_reg != '1))
        drop_reg <= drop_reg + DROP_CNT_WIDTH'(1);
    end
  end

  // Storage: write and read ports always address opposite banks while a frame is held.
  always_ff @(posedge clk) begin
    if (accept)
      mem[{write_bank_reg, fill_reg[AW-1:0]}] <= bus.i_sample;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rdata_reg <= '0;
    else
      rdata_reg <= mem[{read_bank_reg, bus.i_read_addr}];
  end

  assign bus.o_read_data  = rdata_reg;
  assign bus.o_data_ready = ready_reg;
  assign bus.o_write_bank = write_bank_reg;
  assign bus.o_fill_count = fill_reg;
  assign bus.o_overrun    = overrun_reg;
  assign bus.o_drop_count = drop_reg;
endmodule

// File: tb/tb_audio_frame_double_buffer.sv
// Directed plus random bench for the ping-pong frame buffer.
// Two instances share stimulus: one with a wide and one with a 2-bit drop counter.
module tb_audio_frame_double_buffer;
  localparam int N  = 8;
  localparam int DW = 24;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  audio_frame_double_buffer_if #(.FFT_POINTS(N), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(16)) bus_w ();
  audio_frame_double_buffer_if #(.FFT_POINTS(N), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(2))  bus_n ();

  assign bus_n.i_sample_valid = bus_w.i_sample_valid;
  assign bus_n.i_sample       = bus_w.i_sample;
  assign bus_n.i_read_addr    = bus_w.i_read_addr;
  assign bus_n.i_fft_busy     = bus_w.i_fft_busy;

  audio_frame_double_buffer #(.FFT_POINTS(N), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(16)) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w.slave)
  );

  audio_frame_double_buffer #(.FFT_POINTS(N), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(2)) dut_n (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_n.slave)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference model: frames as arrays, consumer as offered/claimed flags.
  int  m_mem [2][N];
  bit  m_offered, m_claimed;
  int  m_wbank, m_rbank, m_fill, m_drops;
  bit  m_rbank_known, m_waiting, m_overrun;
  int  m_rdata;
  bit  m_rdata_chk;

  task automatic model_step();
    bit v, busy, done;
    int s, a;
    v = bus_w.i_sample_valid; busy = bus_w.i_fft_busy;
    s = int'(bus_w.i_sample); a = int'(bus_w.i_read_addr);
    if (reset) begin
      m_offered = 0; m_claimed = 0; m_wbank = 0; m_fill = 0; m_drops = 0;
      m_rbank_known = 0; m_waiting = 0; m_overrun = 0; m_rdata = 0; m_rdata_chk = 1;
      return;
    end
    m_rdata_chk = m_rbank_known;
    if (m_rbank_known) m_rdata = m_mem[m_rbank][a];
    m_overrun = v && m_waiting;
    if (v && m_waiting) m_drops++;
    done = 0;
    if (v && !m_waiting) begin
      m_mem[m_wbank][m_fill] = s;
      m_fill++;
      done = (m_fill == N);
    end
    if (m_offered && busy) begin m_offered = 0; m_claimed = 1; end
    else if (m_claimed && !busy) m_claimed = 0;
    if (done || m_waiting) begin
      if (!m_offered && !m_claimed) begin
        m_rbank = m_wbank; m_rbank_known = 1; m_wbank = 1 - m_wbank;
        m_fill = 0; m_waiting = 0; m_offered = 1;
      end else begin
        m_waiting = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("ready",      bus_w.o_data_ready, m_offered);
    check("write_bank", bus_w.o_write_bank, m_wbank);
    check("fill",       bus_w.o_fill_count, m_fill);
    check("overrun",    bus_w.o_overrun, m_overrun);
    check("drops_w",    bus_w.o_drop_count, (m_drops > 65535) ? 65535 : m_drops);
    check("overrun_n",  bus_n.o_overrun, m_overrun);
    check("drops_n",    bus_n.o_drop_count, (m_drops > 3) ? 3 : m_drops);
    check("ready_n",    bus_n.o_data_ready, m_offered);
    if (m_rdata_chk) check("rdata", bus_w.o_read_data, m_rdata[DW-1:0]);
  endtask

  task automatic drive(input bit v, input int s, input bit busy, input int addr);
    bus_w.i_sample_valid = v;
    bus_w.i_sample       = s[DW-1:0];
    bus_w.i_fft_busy     = busy;
    bus_w.i_read_addr    = addr[AW-1:0];
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  int  ovr;
  bit  rbusy, rv, rrst;

  initial begin
    bus_w.i_sample_valid = 0; bus_w.i_sample = '0; bus_w.i_fft_busy = 0; bus_w.i_read_addr = '0;
    reset = 1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    reset = 0;
    check("rst_rdata", bus_w.o_read_data, 0);

    // First frame 1..8 lands in bank 0 and is offered immediately.
    for (int i = 0; i < N; i++) drive(1, i + 1, 0, 0);
    check("f1_ready", bus_w.o_data_ready, 1);
    check("f1_wbank", bus_w.o_write_bank, 1);
    check("f1_fill",  bus_w.o_fill_count, 0);
    for (int i = 0; i < N; i++) begin
      drive(0, 0, 0, i);
      check("f1_rd", bus_w.o_read_data, i + 1);
    end

    // Claim, then stream 9..16 into bank 1 while bank 0 is read.
    drive(0, 0, 1, 0);
    check("claim_ready", bus_w.o_data_ready, 0);
    for (int i = 0; i < N; i++) begin
      drive(1, 9 + i, 1, i);
      check("claim_rd", bus_w.o_read_data, i + 1);
    end

    // Three extra samples while still busy are dropped.
    ovr = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 500 + i, 1, 0);
      if (bus_w.o_overrun) ovr++;
    end
    check("ovr3_pulses", ovr, 3);
    check("ovr3_fill",   bus_w.o_fill_count, N);
    check("ovr3_drops",  bus_w.o_drop_count, 3);
    drive(0, 0, 0, 0);
    check("rel_ready", bus_w.o_data_ready, 1);
    check("rel_wbank", bus_w.o_write_bank, 0);
    for (int i = 0; i < N; i++) begin
      drive(0, 0, 0, i);
      check("f2_rd", bus_w.o_read_data, 9 + i);
    end

    // Eighth sample coincides with busy falling: swap without a drop.
    drive(0, 0, 1, 0);
    for (int i = 0; i < N - 1; i++) drive(1, 100 + i, 1, 0);
    drive(1, 107, 0, 0);
    check("coin_ovr",   bus_w.o_overrun, 0);
    check("coin_ready", bus_w.o_data_ready, 1);
    check("coin_drops", bus_w.o_drop_count, 3);

    // Reset mid-frame, then a clean frame in bank 0.
    for (int i = 0; i < 5; i++) drive(1, 300 + i, 0, 0);
    reset = 1;
    drive(0, 0, 0, 0);
    reset = 0;
    check("mid_rst_ready", bus_w.o_data_ready, 0);
    check("mid_rst_wbank", bus_w.o_write_bank, 0);
    check("mid_rst_fill",  bus_w.o_fill_count, 0);
    check("mid_rst_drops", bus_w.o_drop_count, 0);
    check("mid_rst_rdata", bus_w.o_read_data, 0);
    for (int i = 0; i < N; i++) drive(1, 200 + i, 0, 0);
    check("f3_wbank", bus_w.o_write_bank, 1);
    for (int i = 0; i < N; i++) begin
      drive(0, 0, 0, i);
      check("f3_rd", bus_w.o_read_data, 200 + i);
    end

    // Six drops: 2-bit counter saturates at 3.
    drive(0, 0, 1, 0);
    for (int i = 0; i < N; i++) drive(1, 400 + i, 1, 0);
    ovr = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 600 + i, 1, 0);
      if (bus_n.o_overrun) ovr++;
    end
    check("sat_pulses", ovr, 6);
    check("sat_drops_n", bus_n.o_drop_count, 3);
    check("sat_drops_w", bus_w.o_drop_count, 6);
    drive(0, 0, 0, 0);

    // Random traffic with a bursty consumer and occasional resets.
    rbusy = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) rbusy = ~rbusy;
      rv   = ($urandom_range(0, 9) < 6);
      rrst = ($urandom_range(0, 299) == 0);
      reset = rrst;
      drive(rv, int'($urandom), rbusy, int'($urandom_range(0, N - 1)));
    end
    reset = 0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
